// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle tinymips datapath: sequences fetch, decode,
// execute and writeback over a shared memory port with an optional wait-state handshake.
module multicycle_controller #(
  parameter logic MEM_WAIT         = 1'b1,
  parameter logic ENABLE_BNE       = 1'b1,
  parameter logic ENABLE_IMM_LOGIC = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Memory handshake: mem_req stays high, with iord/memwrite stable, for the whole
  // access; the access completes in the cycle where mem_req && rdy, and only then
  // does the FSM leave FETCH/MEMRD/MEMWR. mem_ready is ignored when MEM_WAIT = 0.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     cur;
  state_t     dec_next;
  logic       dec_illegal;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       rdy;

  assign rdy   = MEM_WAIT ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Disabled optional opcodes fall through to the illegal path.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_ok) dec_next = S_EXECUTE;
        else          dec_illegal = 1'b1;
      end
      OP_BEQ: dec_next = S_BRANCH;
      OP_BNE: begin
        if (ENABLE_BNE) dec_next = S_BRANCH;
        else            dec_illegal = 1'b1;
      end
      OP_ADDI: dec_next = S_IMMEXEC;
      OP_ANDI, OP_ORI: begin
        if (ENABLE_IMM_LOGIC) dec_next = S_IMMEXEC;
        else                  dec_illegal = 1'b1;
      end
      OP_J:    dec_next = S_JUMP;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur        <= S_IDLE;
      illegal_op <= 1'b0;
    end else begin
      case (cur)
        S_IDLE:   cur <= S_FETCH;
        S_FETCH:  if (rdy) cur <= S_DECODE;
        S_DECODE: begin
          cur <= dec_next;
          if (dec_illegal) illegal_op <= 1'b1;
        end
        S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (rdy) cur <= S_MEMWB;
        S_MEMWB:   cur <= S_FETCH;
        S_MEMWR:   if (rdy) cur <= S_FETCH;
        S_EXECUTE: cur <= S_ALUWB;
        S_ALUWB:   cur <= S_FETCH;
        S_BRANCH:  cur <= S_FETCH;
        S_IMMEXEC: cur <= S_IMMWB;
        S_IMMWB:   cur <= S_FETCH;
        S_JUMP:    cur <= S_FETCH;
        default:   cur <= S_FETCH;
      endcase
    end
  end

  // Outputs follow the state register, so an async reset drops them immediately.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    alucontrol = 3'b000;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = rdy;
        pcen       = rdy;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        instr_done = dec_illegal;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = rdy;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin
            alucontrol = ALU_AND;
            zeroext    = 1'b1;
          end
          OP_ORI: begin
            alucontrol = ALU_OR;
            zeroext    = 1'b1;
          end
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control words for a default
// instance and a MEM_WAIT=0 / optional-opcodes-disabled instance.
module tb_multicycle_controller;

  localparam int W = 23;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECUTE = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_IMMEXEC = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       done;
    logic       ill;
  } out_t;

  typedef struct {
    logic       sel;
    logic       rstn;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  // clock / reset
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       m_reset_n = 1'b0, a_reset_n = 1'b0;
  logic [5:0] m_op = '0, m_funct = '0, a_op = '0, a_funct = '0;
  logic       m_zero = 1'b0, m_mem_ready = 1'b1, a_zero = 1'b0, a_mem_ready = 1'b1;

  logic       m_mem_req, m_iord, m_memwrite, m_irwrite, m_pcen, m_alusrca, m_zeroext;
  logic       m_regdst, m_memtoreg, m_regwrite, m_instr_done, m_illegal_op;
  logic [1:0] m_pcsrc, m_alusrcb;
  logic [2:0] m_alucontrol;
  logic [3:0] m_state;
  logic       a_mem_req, a_iord, a_memwrite, a_irwrite, a_pcen, a_alusrca, a_zeroext;
  logic       a_regdst, a_memtoreg, a_regwrite, a_instr_done, a_illegal_op;
  logic [1:0] a_pcsrc, a_alusrcb;
  logic [2:0] a_alucontrol;
  logic [3:0] a_state;

  multicycle_controller dut (
    .clk(clk), .reset_n(m_reset_n), .op(m_op), .funct(m_funct), .zero(m_zero),
    .mem_ready(m_mem_ready), .mem_req(m_mem_req), .iord(m_iord), .memwrite(m_memwrite),
    .irwrite(m_irwrite), .pcen(m_pcen), .pcsrc(m_pcsrc), .alusrca(m_alusrca),
    .alusrcb(m_alusrcb), .zeroext(m_zeroext), .alucontrol(m_alucontrol),
    .regdst(m_regdst), .memtoreg(m_memtoreg), .regwrite(m_regwrite),
    .instr_done(m_instr_done), .illegal_op(m_illegal_op), .state(m_state)
  );

  multicycle_controller #(
    .MEM_WAIT(1'b0), .ENABLE_BNE(1'b0), .ENABLE_IMM_LOGIC(1'b0)
  ) dut_alt (
    .clk(clk), .reset_n(a_reset_n), .op(a_op), .funct(a_funct), .zero(a_zero),
    .mem_ready(a_mem_ready), .mem_req(a_mem_req), .iord(a_iord), .memwrite(a_memwrite),
    .irwrite(a_irwrite), .pcen(a_pcen), .pcsrc(a_pcsrc), .alusrca(a_alusrca),
    .alusrcb(a_alusrcb), .zeroext(a_zeroext), .alucontrol(a_alucontrol),
    .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite),
    .instr_done(a_instr_done), .illegal_op(a_illegal_op), .state(a_state)
  );

  out_t m_act, a_act;
  assign m_act = {m_state, m_mem_req, m_iord, m_memwrite, m_irwrite, m_pcen, m_pcsrc,
                  m_alusrca, m_alusrcb, m_zeroext, m_alucontrol, m_regdst, m_memtoreg,
                  m_regwrite, m_instr_done, m_illegal_op};
  assign a_act = {a_state, a_mem_req, a_iord, a_memwrite, a_irwrite, a_pcen, a_pcsrc,
                  a_alusrca, a_alusrcb, a_zeroext, a_alucontrol, a_regdst, a_memtoreg,
                  a_regwrite, a_instr_done, a_illegal_op};

  // expected control word for each state, straight from the state table
  function automatic out_t x_base(logic [3:0] st, logic ill);
    out_t r = '0;
    r.st  = st;
    r.ill = ill;
    return r;
  endfunction
  function automatic out_t x_idle();
    return x_base(S_IDLE, 1'b0);
  endfunction
  function automatic out_t x_fetch(logic rdy, logic ill);
    out_t r = x_base(S_FETCH, ill);
    r.mem_req = 1'b1; r.alusrcb = 2'b01; r.aluc = 3'b010; r.irwrite = rdy; r.pcen = rdy;
    return r;
  endfunction
  function automatic out_t x_decode(logic done, logic ill);
    out_t r = x_base(S_DECODE, ill);
    r.alusrcb = 2'b11; r.aluc = 3'b010; r.done = done;
    return r;
  endfunction
  function automatic out_t x_memadr(logic ill);
    out_t r = x_base(S_MEMADR, ill);
    r.alusrca = 1'b1; r.alusrcb = 2'b10; r.aluc = 3'b010;
    return r;
  endfunction
  function automatic out_t x_memrd(logic ill);
    out_t r = x_base(S_MEMRD, ill);
    r.mem_req = 1'b1; r.iord = 1'b1;
    return r;
  endfunction
  function automatic out_t x_memwb(logic ill);
    out_t r = x_base(S_MEMWB, ill);
    r.memtoreg = 1'b1; r.regwrite = 1'b1; r.done = 1'b1;
    return r;
  endfunction
  function automatic out_t x_memwr(logic rdy, logic ill);
    out_t r = x_base(S_MEMWR, ill);
    r.mem_req = 1'b1; r.iord = 1'b1; r.memwrite = 1'b1; r.done = rdy;
    return r;
  endfunction
  function automatic out_t x_exec(logic [2:0] aluc);
    out_t r = x_base(S_EXECUTE, 1'b0);
    r.alusrca = 1'b1; r.aluc = aluc;
    return r;
  endfunction
  function automatic out_t x_aluwb();
    out_t r = x_base(S_ALUWB, 1'b0);
    r.regdst = 1'b1; r.regwrite = 1'b1; r.done = 1'b1;
    return r;
  endfunction
  function automatic out_t x_branch(logic pcen);
    out_t r = x_base(S_BRANCH, 1'b0);
    r.alusrca = 1'b1; r.aluc = 3'b110; r.pcsrc = 2'b01; r.pcen = pcen; r.done = 1'b1;
    return r;
  endfunction
  function automatic out_t x_immexec(logic [2:0] aluc, logic zext);
    out_t r = x_base(S_IMMEXEC, 1'b0);
    r.alusrca = 1'b1; r.alusrcb = 2'b10; r.aluc = aluc; r.zeroext = zext;
    return r;
  endfunction
  function automatic out_t x_immwb();
    out_t r = x_base(S_IMMWB, 1'b0);
    r.regwrite = 1'b1; r.done = 1'b1;
    return r;
  endfunction
  function automatic out_t x_jump(logic ill);
    out_t r = x_base(S_JUMP, ill);
    r.pcsrc = 2'b10; r.pcen = 1'b1; r.done = 1'b1;
    return r;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           vec_count = 0;
  int           miscompares = 0;

  task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    vec_count++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic add(input logic sel, input logic rstn, input logic [5:0] op,
                     input logic [5:0] funct, input logic zero, input logic rdy,
                     input out_t exp);
    vec_t v;
    v.sel = sel; v.rstn = rstn; v.op = op; v.funct = funct;
    v.zero = zero; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  // driver: inputs change on the falling edge, outputs are checked 2 ns later
  task automatic step(input logic sel, input logic rstn, input logic [5:0] op,
                      input logic [5:0] funct, input logic zero, input logic rdy,
                      input out_t exp, input string name);
    logic [W-1:0] want;
    @(negedge clk);
    if (!sel) begin
      m_reset_n = rstn; m_op = op; m_funct = funct; m_zero = zero; m_mem_ready = rdy;
    end else begin
      a_reset_n = rstn; a_op = op; a_funct = funct; a_zero = zero; a_mem_ready = rdy;
    end
    exp_q.push_back(exp);
    #2;
    want = exp_q.pop_front();
    compare(name, sel ? a_act : m_act, want);
  endtask

  initial begin
    // default instance: reset, lw, sw with wait states
    add(0, 0, LW, RT, 0, 1, x_idle());
    add(0, 1, LW, RT, 0, 1, x_idle());
    add(0, 1, LW, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, LW, RT, 0, 1, x_decode(0, 0));
    add(0, 1, LW, RT, 0, 1, x_memadr(0));
    add(0, 1, LW, RT, 0, 1, x_memrd(0));
    add(0, 1, LW, RT, 0, 1, x_memwb(0));
    add(0, 1, SW, RT, 0, 0, x_fetch(0, 0));
    add(0, 1, SW, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, SW, RT, 0, 1, x_decode(0, 0));
    add(0, 1, SW, RT, 0, 1, x_memadr(0));
    for (int i = 0; i < 3; i++) add(0, 1, SW, RT, 0, 0, x_memwr(0, 0));
    add(0, 1, SW, RT, 0, 1, x_memwr(1, 0));
    // R-type: slt, sub, or
    add(0, 1, RT, 6'b101010, 0, 1, x_fetch(1, 0));
    add(0, 1, RT, 6'b101010, 0, 1, x_decode(0, 0));
    add(0, 1, RT, 6'b101010, 0, 1, x_exec(3'b111));
    add(0, 1, RT, 6'b101010, 0, 1, x_aluwb());
    add(0, 1, RT, 6'b100010, 0, 1, x_fetch(1, 0));
    add(0, 1, RT, 6'b100010, 0, 1, x_decode(0, 0));
    add(0, 1, RT, 6'b100010, 0, 1, x_exec(3'b110));
    add(0, 1, RT, 6'b100010, 0, 1, x_aluwb());
    add(0, 1, RT, 6'b100101, 0, 1, x_fetch(1, 0));
    add(0, 1, RT, 6'b100101, 0, 1, x_decode(0, 0));
    add(0, 1, RT, 6'b100101, 0, 1, x_exec(3'b001));
    add(0, 1, RT, 6'b100101, 0, 1, x_aluwb());
    // branches: beq/bne with both zero values
    add(0, 1, BEQ, RT, 1, 1, x_fetch(1, 0));
    add(0, 1, BEQ, RT, 1, 1, x_decode(0, 0));
    add(0, 1, BEQ, RT, 1, 1, x_branch(1));
    add(0, 1, BEQ, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, BEQ, RT, 0, 1, x_decode(0, 0));
    add(0, 1, BEQ, RT, 0, 1, x_branch(0));
    add(0, 1, BNE, RT, 1, 1, x_fetch(1, 0));
    add(0, 1, BNE, RT, 1, 1, x_decode(0, 0));
    add(0, 1, BNE, RT, 1, 1, x_branch(0));
    add(0, 1, BNE, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, BNE, RT, 0, 1, x_decode(0, 0));
    add(0, 1, BNE, RT, 0, 1, x_branch(1));
    // immediates and jump
    add(0, 1, ADDI, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, ADDI, RT, 0, 1, x_decode(0, 0));
    add(0, 1, ADDI, RT, 0, 1, x_immexec(3'b010, 0));
    add(0, 1, ADDI, RT, 0, 1, x_immwb());
    add(0, 1, ORI, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, ORI, RT, 0, 1, x_decode(0, 0));
    add(0, 1, ORI, RT, 0, 1, x_immexec(3'b001, 1));
    add(0, 1, ORI, RT, 0, 1, x_immwb());
    add(0, 1, ANDI, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, ANDI, RT, 0, 1, x_decode(0, 0));
    add(0, 1, ANDI, RT, 0, 1, x_immexec(3'b000, 1));
    add(0, 1, ANDI, RT, 0, 1, x_immwb());
    add(0, 1, J, RT, 0, 1, x_fetch(1, 0));
    add(0, 1, J, RT, 0, 1, x_decode(0, 0));
    add(0, 1, J, RT, 0, 1, x_jump(0));
    // illegal funct, then sticky flag through a normal lw and an illegal opcode
    add(0, 1, RT, 6'b000111, 0, 1, x_fetch(1, 0));
    add(0, 1, RT, 6'b000111, 0, 1, x_decode(1, 0));
    add(0, 1, LW, RT, 0, 1, x_fetch(1, 1));
    add(0, 1, LW, RT, 0, 1, x_decode(0, 1));
    add(0, 1, LW, RT, 0, 1, x_memadr(1));
    add(0, 1, LW, RT, 0, 1, x_memrd(1));
    add(0, 1, LW, RT, 0, 1, x_memwb(1));
    add(0, 1, BAD, RT, 0, 1, x_fetch(1, 1));
    add(0, 1, BAD, RT, 0, 1, x_decode(1, 1));
    add(0, 1, J, RT, 0, 1, x_fetch(1, 1));
    add(0, 1, J, RT, 0, 1, x_decode(0, 1));
    add(0, 1, J, RT, 0, 1, x_jump(1));

    // MEM_WAIT=0 instance: mem_ready low is ignored; bne/ori/andi are illegal
    add(1, 0, SW, RT, 0, 0, x_idle());
    add(1, 1, SW, RT, 0, 0, x_idle());
    add(1, 1, SW, RT, 0, 0, x_fetch(1, 0));
    add(1, 1, SW, RT, 0, 0, x_decode(0, 0));
    add(1, 1, SW, RT, 0, 0, x_memadr(0));
    add(1, 1, SW, RT, 0, 0, x_memwr(1, 0));
    add(1, 1, ORI, RT, 0, 0, x_fetch(1, 0));
    add(1, 1, ORI, RT, 0, 0, x_decode(1, 0));
    add(1, 1, ORI, RT, 0, 0, x_fetch(1, 1));
    add(1, 0, BNE, RT, 0, 1, x_idle());
    add(1, 1, BNE, RT, 0, 1, x_idle());
    add(1, 1, BNE, RT, 0, 1, x_fetch(1, 0));
    add(1, 1, BNE, RT, 0, 1, x_decode(1, 0));
    add(1, 1, BNE, RT, 0, 1, x_fetch(1, 1));
    add(1, 0, ANDI, RT, 0, 1, x_idle());
    add(1, 1, ANDI, RT, 0, 1, x_idle());
    add(1, 1, ANDI, RT, 0, 1, x_fetch(1, 0));
    add(1, 1, ANDI, RT, 0, 1, x_decode(1, 0));
    add(1, 1, ANDI, RT, 0, 1, x_fetch(1, 1));

    foreach (vecs[i])
      step(vecs[i].sel, vecs[i].rstn, vecs[i].op, vecs[i].funct, vecs[i].zero,
           vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));

    // reset during a stalled store: state and memwrite drop without a clock edge
    step(0, 0, SW, RT, 0, 1, x_idle(), "rst_clears_illegal");
    step(0, 1, SW, RT, 0, 1, x_idle(), "rst_release");
    step(0, 1, SW, RT, 0, 1, x_fetch(1, 0), "sw_fetch");
    step(0, 1, SW, RT, 0, 1, x_decode(0, 0), "sw_decode");
    step(0, 1, SW, RT, 0, 1, x_memadr(0), "sw_memadr");
    step(0, 1, SW, RT, 0, 0, x_memwr(0, 0), "sw_wait");
    #1 m_reset_n = 1'b0;
    #1;
    compare("async_reset_word", m_act, x_idle());
    compare("async_memwrite_drop", {{(W-1){1'b0}}, m_memwrite}, '0);
    step(0, 0, SW, RT, 0, 0, x_idle(), "held_reset");
    step(0, 1, LW, RT, 0, 1, x_idle(), "resume_idle");
    step(0, 1, LW, RT, 0, 1, x_fetch(1, 0), "resume_fetch");
    step(0, 1, LW, RT, 0, 1, x_decode(0, 0), "resume_decode");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style control FSM for the multicycle tinymips datapath. It replaces per-instruction combinational decode with a sequenced fetch/decode/execute/writeback flow. The PC, memory and register file are shared across cycles. A memory wait-state handshake is added, plus parameter-gated bne, andi and ori support and illegal-instruction detection. It sits between the instruction register (op/funct), the ALU zero flag, the shared memory port and the multicycle datapath muxes and enables.

Parameters:
MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1 (fixed 1-cycle memory)
ENABLE_BNE, 1, 1 = opcode 000101 (bne) legal
ENABLE_IMM_LOGIC, 1, 1 = opcodes 001100 (andi) and 001101 (ori) legal

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
op  input  6  instruction opcode from instruction register
funct  input  6  R-type function field
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access in progress (FETCH, MEMRD, MEMWR)
iord  output  1  memory address: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe (held until mem_ready)
irwrite  output  1  load instruction register
pcen  output  1  PC load enable
pcsrc  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
alusrca  output  1  0 = PC, 1 = register A
alusrcb  output  2  00 = B, 01 = const 4, 10 = extended imm, 11 = sign-ext imm << 2
zeroext  output  1  1 = immediate zero-extended (andi/ori)
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = write data from memory
regwrite  output  1  register file write enable
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal_op  output  1  sticky; set on undecodable instruction
state  output  4  current FSM state, for the monitor

Behaviour:
- Reset (reset_n low, async): state = IDLE, illegal_op = 0. All outputs are 0 while in IDLE, including alucontrol = 000.
- IDLE -> FETCH unconditionally on the first clk edge after reset release.
- rdy = mem_ready when MEM_WAIT = 1, else 1.
- Outputs are decoded from state only (Moore). Exceptions: irwrite, pcen and instr_done are additionally qualified by rdy or zero, as listed below. Any output not listed for a state is 0.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, add, pcsrc = 00, irwrite = pcen = rdy. Stay while !rdy; else go to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, add (branch target -> ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - 000000 with legal funct -> EXECUTE
  - beq, or bne when enabled -> BRANCH
  - addi, or andi/ori when enabled -> IMMEXEC
  - j (000010) -> JUMP
  - anything else -> FETCH, with illegal_op <= 1 and instr_done = 1. No write occurs.
- Legal funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
- MEMADR: alusrca = 1, alusrcb = 10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req = 1, iord = 1. Stay while !rdy; else go to MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1, instr_done = 1 -> FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = 1, instr_done = rdy. Stay while !rdy; else go to FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00, alucontrol from funct -> ALUWB.
- ALUWB: regdst = 1, regwrite = 1, instr_done = 1 -> FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, sub, pcsrc = 01. pcen = zero for beq, ~zero for bne. instr_done = 1 -> FETCH.
- IMMEXEC: alusrca = 1, alusrcb = 10. addi: add, zeroext = 0. andi: and, zeroext = 1. ori: or, zeroext = 1. -> IMMWB.
- IMMWB: regdst = 0, regwrite = 1, instr_done = 1 -> FETCH.
- JUMP: pcsrc = 10, pcen = 1, instr_done = 1 -> FETCH.
- Latency with rdy always 1: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, illegal 2 cycles.
- A disabled opcode (ENABLE_* = 0) is handled exactly as an illegal opcode.
- Reset asserted mid-instruction: immediate return to IDLE; an in-flight memwrite drops asynchronously.
- illegal_op clears only on reset.
- Unused state encodings -> FETCH on the next edge.

Test Plan:
- Reset released, mem_ready = 1, op = 100011 (lw) -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite = 1 and memtoreg = 1 only in MEMWB; instr_done pulses once.
- MEM_WAIT = 1, sw, mem_ready low for 3 cycles in MEMWR -> memwrite = 1 for 4 cycles, instr_done only in the final cycle; MEM_WAIT = 0 with the same stimulus -> 1 cycle.
- R-type funct 101010 -> alucontrol = 111 in EXECUTE, regdst = 1 in ALUWB; funct 000111 -> illegal_op = 1, return to FETCH, no regwrite.
- beq with zero = 1 -> pcen = 1, pcsrc = 01; zero = 0 -> pcen = 0; bne inverts both; ENABLE_BNE = 0 -> op 000101 sets illegal_op.
- ori (001101) -> zeroext = 1, alucontrol = 001, alusrcb = 10 in IMMEXEC; ENABLE_IMM_LOGIC = 0 -> illegal path; j -> pcsrc = 10, pcen = 1, total 3 cycles.
- reset_n pulsed low during MEMWR wait -> state = IDLE and memwrite = 0 asynchronously; illegal_op cleared; normal fetch resumes after release.
